// File: rtl/fmac_sync_fifo.sv
// Single-clock FIFO with usedw-decoded status flags, sticky error flags
// and optional first-word fall-through read port.
module fmac_sync_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 512,
    parameter int PTR       = 9,
    parameter int AFULL_TH  = 496,
    parameter int AEMPTY_TH = 16,
    parameter bit SHOWAHEAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR:0]     usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR:0] DEPTH_W  = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_W  = (PTR+1)'(AFULL_TH);
    localparam logic [PTR:0] AEMPTY_W = (PTR+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR-1:0]   wr_ptr;
    logic [PTR-1:0]   rd_ptr;
    logic [PTR:0]     cnt;
    logic             ovf_r;
    logic             udf_r;
    logic             wr_en;
    logic             rd_en;

    assign full         = (cnt == DEPTH_W);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AFULL_W);
    assign almost_empty = (cnt <= AEMPTY_W);
    assign usedw        = cnt;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

    // sclr wins over both requests in its cycle
    assign wr_en = wrreq & ~full & ~sclr;
    assign rd_en = rdreq & ~empty & ~sclr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wrreq && full) begin
                ovf_r <= 1'b1;
            end
            if (rdreq && empty) begin
                udf_r <= 1'b1;
            end
        end
    end

    generate
        if (SHOWAHEAD) begin : g_fwft
            // Head word is visible as soon as it is counted; 0 while empty
            assign q = empty ? '0 : mem[rd_ptr];
        end else begin : g_norm
            logic [WIDTH-1:0] q_r;
            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    q_r <= '0;
                end else if (sclr) begin
                    q_r <= '0;
                end else if (rd_en) begin
                    q_r <= mem[rd_ptr];
                end
            end
            assign q = q_r;
        end
    endgenerate

endmodule
